// File: rtl/mult_display_ctrl.sv
// Display front-end: converts a signed 16-bit product to sign + five BCD digits
// with a sequential double-dabble engine and scans them onto a 4-position display.
module mult_display_ctrl #(
    parameter int REFRESH_CNT = 100000,
    parameter int CNT_W       = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               value_valid,
    input  logic signed [15:0] value,
    input  logic               win,
    output logic               busy,
    output logic [1:0]         en,
    output logic [3:0]         num
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t             state;
    logic [3:0]         shcnt;
    logic [19:0]        bcd;
    logic [19:0]        bcd_adj;
    logic [15:0]        mag;
    logic               sign;
    logic               disp_sign;
    logic [3:0]         d4, d3, d2, d1, d0;
    logic [CNT_W-1:0]   rcnt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // 0x8000 maps to 32768, which still fits the 16-bit unsigned magnitude.
    function automatic logic [15:0] abs16(input logic signed [15:0] v);
        logic [15:0] r;
        r = v;
        return v[15] ? (~r + 16'd1) : r;
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd[19:16]), add3(bcd[15:12]), add3(bcd[11:8]),
                   add3(bcd[7:4]), add3(bcd[3:0])};
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && value_valid) begin
            sign <= value[15];
            mag  <= abs16(value);
            bcd  <= 20'd0;
        end else if (state == CONV) begin
            bcd <= {bcd_adj[18:0], mag[15]};
            mag <= {mag[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            shcnt     <= 4'd0;
            disp_sign <= 1'b0;
            d4        <= 4'd0;
            d3        <= 4'd0;
            d2        <= 4'd0;
            d1        <= 4'd0;
            d0        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        shcnt <= 4'd0;
                    end
                end
                CONV: begin
                    shcnt <= shcnt + 4'd1;
                    if (shcnt == 4'd15)
                        state <= COMMIT;
                end
                COMMIT: begin
                    d4        <= bcd[19:16];
                    d3        <= bcd[15:12];
                    d2        <= bcd[11:8];
                    d1        <= bcd[7:4];
                    d0        <= bcd[3:0];
                    disp_sign <= sign;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Refresh scan is free-running and independent of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            en   <= 2'd0;
        end else if (rcnt == CNT_W'(REFRESH_CNT - 1)) begin
            rcnt <= '0;
            en   <= en + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    always_comb begin
        num = 4'd0;
        case (en)
            2'd0: num = disp_sign ? 4'd10 : 4'd0;
            2'd1: num = win ? d4 : d2;
            2'd2: num = win ? d3 : d1;
            2'd3: num = win ? d2 : d0;
            default: num = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_display_ctrl.sv
// Scoreboard bench for mult_display_ctrl: stimulus queues expected displays,
// a monitor checks busy length and scans every position in both windows.
module tb_mult_display_ctrl;

    typedef struct {
        logic       sgn;
        logic [3:0] d4, d3, d2, d1, d0;
    } disp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               value_valid = 1'b0;
    logic signed [15:0] value = '0;
    logic               win;
    logic               busy;
    logic [1:0]         en;
    logic [3:0]         num;

    int    checks = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    scan_req = 0;
    disp_t expq[$];

    logic [1:0] mcnt, men;

    mult_display_ctrl #(.REFRESH_CNT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
        .win(win), .busy(busy), .en(en), .num(num)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int exp_num(input disp_t r, input logic [1:0] pos, input logic w);
        case (pos)
            2'd0: return r.sgn ? 10 : 0;
            2'd1: return w ? int'(r.d4) : int'(r.d2);
            2'd2: return w ? int'(r.d3) : int'(r.d1);
            default: return w ? int'(r.d2) : int'(r.d0);
        endcase
    endfunction

    function automatic disp_t mk(input logic s, input int a, input int b, input int c,
                                 input int d, input int e);
        disp_t r;
        r.sgn = s; r.d4 = 4'(a); r.d3 = 4'(b); r.d2 = 4'(c); r.d1 = 4'(d); r.d0 = 4'(e);
        return r;
    endfunction

    // Reference scan position: REFRESH_CNT=4 cycles per position.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 2'd0;
            men  <= 2'd0;
        end else begin
            mcnt <= mcnt + 2'd1;
            if (mcnt == 2'd3) men <= men + 2'd1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("en_scan", int'(en), int'(men));
        end
    end

    // Monitor: on every busy fall (or explicit scan request) pop and verify.
    initial begin
        int    blen = 0;
        logic  prev = 1'b0;
        int    seen = 0;
        disp_t r;
        win = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                blen = 0;
                prev = 1'b0;
                continue;
            end
            if (busy) blen = prev ? blen + 1 : 1;
            if ((prev && !busy) || (scan_req != seen)) begin
                if (prev && !busy) check("busy_len", blen, 17);
                else seen = scan_req;
                if (expq.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    r = expq.pop_front();
                    for (int w = 0; w < 2; w++) begin
                        win = w[0];
                        for (int k = 0; k < 16; k++) begin
                            @(negedge clk);
                            #1;
                            check($sformatf("num_w%0d_en%0d", w, en), int'(num),
                                  exp_num(r, en, w[0]));
                        end
                    end
                    win = 1'b0;
                end
                done_cnt++;
            end
            prev = busy;
        end
    end

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        value = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < n) check("timeout_done", done_cnt, n);
    endtask

    initial begin
        int n = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_en", int'(en), 0);
        check("rst_num", int'(num), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Display after reset: zeros everywhere, scan steps every 4 cycles.
        expq.push_back(mk(0, 0, 0, 0, 0, 0)); scan_req++; n++; wait_done(n);

        expq.push_back(mk(0, 1, 2, 3, 4, 5)); strobe(16'h3039); n++; wait_done(n);
        expq.push_back(mk(1, 1, 6, 3, 8, 4)); strobe(16'hC000); n++; wait_done(n);
        expq.push_back(mk(1, 0, 0, 0, 0, 1)); strobe(16'hFFFF); n++; wait_done(n);

        // A strobe in the middle of a conversion is dropped.
        expq.push_back(mk(0, 0, 0, 0, 0, 7)); strobe(16'h0007);
        repeat (3) @(negedge clk);
        strobe(16'h0009);
        n++; wait_done(n);
        expq.push_back(mk(0, 0, 0, 0, 0, 9)); strobe(16'h0009); n++; wait_done(n);

        // Reset during a conversion aborts it and clears the display.
        expq.push_back(mk(0, 0, 0, 0, 9, 9)); strobe(16'h0063); n++; wait_done(n);
        strobe(16'h0001);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_num", int'(num), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expq.push_back(mk(0, 0, 0, 0, 0, 0)); scan_req++; n++; wait_done(n);
        expq.push_back(mk(0, 0, 0, 0, 0, 5)); strobe(16'h0005); n++; wait_done(n);

        expq.push_back(mk(1, 3, 2, 7, 6, 8)); strobe(16'h8000); n++; wait_done(n);
        expq.push_back(mk(0, 0, 0, 0, 0, 0)); strobe(16'h0000); n++; wait_done(n);

        repeat (30) @(negedge clk);
        check("queue_empty", expq.size(), 0);
        check("commit_count", done_cnt, n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_display_ctrl.md
# mult_display_ctrl

Display front-end for the signed multiplier. It accepts a 16-bit signed product on a valid strobe and converts its magnitude to five BCD digits with a sequential double-dabble engine, one shift per cycle. It then time-multiplexes a sign position and three digits onto the four-digit display. It sits directly upstream of the seven-segment decoder and drives that decoder's 2-bit digit-select and 4-bit digit code.

## Interface
- REFRESH_CNT, default 100000: clock cycles each digit position stays selected. Must be ≥ 2.
- CNT_W, default 17: width of the refresh counter. Requires 2^CNT_W ≥ REFRESH_CNT.

Reset is asynchronous and active-low. There is one clock.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value_valid  in  1  one-cycle strobe; value is captured when high and the block is idle.
- value  in  16  signed two's-complement product.
- win  in  1  digit window select:
  - 0: low digits d2 d1 d0.
  - 1: high digits d4 d3 d2.
- busy  out  1  high while a conversion is in progress.
- en  out  2  digit-position select to the decoder; 0 = leftmost position.
- num  out  4  digit code to the decoder: 0–9 = decimal digit, 10 = minus sign.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - On value_valid=1, latch sign = value[15] and mag = |value| as 16-bit unsigned.
  - 0x8000 yields mag 32768; no overflow handling is needed.
  - Clear the 20-bit BCD accumulator and the 4-bit shift counter, then go to CONV.
- CONV, each cycle:
  - For each BCD nibble ≥ 5, add 3.
  - Shift {bcd, mag} left by one.
  - Increment the shift counter.
  - After the 16th shift, go to COMMIT.
- COMMIT:
  - Copy the BCD nibbles to display registers d4..d0 and copy sign to disp_sign.
  - Return to IDLE.
- value_valid in CONV or COMMIT is ignored. It is not queued.
- Display registers hold the last committed value until the next COMMIT. The display never shows partial results.
- Refresh counter:
  - Counts 0..REFRESH_CNT-1 and then wraps to 0.
  - On each wrap, en increments modulo 4 (3 → 0).
- num is combinational from en, win, disp_sign and d4..d0:
  - en=0: 10 if disp_sign=1, otherwise 0.
  - en=1: d4 if win=1, else d2.
  - en=2: d3 if win=1, else d1.
  - en=3: d2 if win=1, else d0.
- win may change at any time. It affects num in the same cycle.
- The refresh scan runs independently of the conversion FSM and is never stalled by it.

## Timing
- Reset values:
  - Asserting rst_n=0 forces state=IDLE and busy=0.
  - en=0, refresh counter=0, d4..d0=0, disp_sign=0.
  - Therefore num=0 while in reset.
- Let E0 be the edge that samples value_valid=1 in IDLE.
  - busy rises after E0.
  - Shifts occur on edges E1..E16.
  - COMMIT updates the display registers on E17.
  - busy falls after E17.
- Total latency from capture to display update is 17 cycles. busy is high for exactly 17 cycles.
- A new value is accepted on the first edge with busy=0, i.e. E17+1 at the earliest. A strobe coincident with E17 is dropped.
- Reset asserted mid-conversion:
  - Aborts the conversion immediately.
  - Display registers return to 0.
  - After release, the block is in IDLE and accepts the next strobe.
- en changes on the edge where the refresh counter wraps. Each position is held for exactly REFRESH_CNT cycles.

## Test plan
- Reset, with REFRESH_CNT=4:
  - Hold rst_n=0 → busy=0, en=0, num=0.
  - Release → en steps 0,1,2,3,0 every 4 cycles. num=0 at every position.
- Conversion latency:
  - value=0x3039 (12345) strobed once → busy high 17 cycles.
  - Afterwards, win=0 gives en=0..3 → num 0,3,4,5.
  - win=1 gives num 0,1,2,3.
- Negative full range:
  - value=0xC000 (−16384) → sign position shows 10.
  - win=1 → 1,6,3. win=0 → 3,8,4.
  - value=0xFFFF (−1) → 10,0,0,1 with win=0.
- Strobe during busy:
  - Strobe 0x0007, then strobe 0x0009 at cycle 5 of busy → display shows 7. busy falls exactly once.
  - A subsequent strobe after busy falls → shows 9.
- Reset mid-operation:
  - Commit 0x0063 (99). Strobe 0x0001, then assert rst_n=0 at cycle 8 of busy.
  - → display regs 0, busy=0 immediately.
  - After release, strobe 0x0005 → shows 5 after 17 cycles.
- Extremes:
  - value=0x8000 → win=1 shows 10,3,2,7. win=0 shows 10,7,6,8.
  - value=0x0000 → 0,0,0,0.
